ask_fsk_modulator: RTL
======================

ASK_FSK_MODULATOR -- requirements
Module: ask_fsk_modulator

Interface
REQ-001 Parameter: BIT_CYCLES, 1024, clocks per serial bit; matches the upstream serializer's bit period.
REQ-002 Parameter: STEP_HI, 8, carrier accumulator step for the high tone (FSK bit 1, all ASK).
REQ-003 Parameter: STEP_LO, 4, carrier accumulator step for the low tone (FSK bit 0).
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: en  in  1  level enable; high = modulate, low = idle.
REQ-007 Port: mode  in  1  0 = ASK, 1 = FSK; sampled only at bit boundaries.
REQ-008 Port: ser_in  in  1  serial data bit from upstream serializer (SerOut).
REQ-009 Port: mod_out  out  8  unsigned modulated carrier sample.
REQ-010 Port: bit_strobe  out  1  one-cycle pulse when a new bit and mode are latched.
REQ-011 Port: busy  out  1  high while in RUN.

Function
REQ-012 FSM states: IDLE, RUN; IDLE->RUN when en=1; RUN->IDLE when en=0; no other transitions.
REQ-013 IDLE->RUN edge: cur_bit<=ser_in, mode_q<=mode, timer<=0, acc<=0, dir<=up, bit_strobe<=1.
REQ-014 In RUN, 10-bit timer increments each cycle; at timer==BIT_CYCLES-1: timer<=0, cur_bit<=ser_in, mode_q<=mode, bit_strobe<=1.
REQ-015 bit_strobe is registered and is 0 in every cycle not covered by REQ-013/REQ-014.
REQ-016 Carrier: 8-bit acc, 1-bit dir, triangle; advances once per RUN cycle, including the timer wrap cycle (phase continuous across bits and mode changes).
REQ-017 Step s = STEP_LO if (mode_q=1 and cur_bit=0), else STEP_HI.
REQ-018 Up: if acc > 255-s then acc<=255, dir<=down; else acc<=acc+s (9-bit compare, no wrap).
REQ-019 Down: if acc < s then acc<=0, dir<=up; else acc<=acc-s.
REQ-020 mod_out = 0 in IDLE; in RUN: ASK -> cur_bit ? acc : 0; FSK -> acc; combinational from registered state only.
REQ-021 busy = (state==RUN); combinational decode of the state register.
REQ-022 mode and ser_in changes between bit boundaries have no effect until the next boundary.
REQ-023 en dropping mid-bit: next cycle IDLE, mod_out=0, busy=0; timer/acc hold and are reinitialised on re-entry per REQ-013.
REQ-024 en held high: operation is free-running; frame alignment to the serializer is achieved by raising en in the cycle the serializer loads.

Reset
REQ-025 rst=1 at a clock edge: state<=IDLE, timer<=0, acc<=0, dir<=up, cur_bit<=0, mode_q<=0, bit_strobe<=0.
REQ-026 rst has priority over en in the same cycle; outputs after reset: mod_out=0, busy=0, bit_strobe=0.
REQ-027 rst mid-RUN aborts the current bit; no bit_strobe is issued for it.

Verification
REQ-028 rst, then en=1, mode=1, ser_in=1 -> busy=1, bit_strobe pulse on entry; acc 0,8,...,248,255,247,... ; next bit_strobe 1024 cycles after the first.
REQ-029 FSK, ser_in=0 -> acc steps 4: 0,4,...,252,255,251; period 2x the ser_in=1 triangle (±1 clamp cycle).
REQ-030 ASK, ser_in alternates per bit (1,0,1) -> mod_out tracks triangle for bit 1, exactly 0 for all 1024 cycles of bit 0; acc keeps advancing underneath.
REQ-031 Toggle mode and ser_in mid-bit (cycle 500) -> step and mod_out unchanged until cycle 1024 boundary, then switch with no acc discontinuity.
REQ-032 en low at cycle 300 of a bit -> next cycle mod_out=0, busy=0; en high again -> acc restarts at 0, strobe pulse, timer restarts at 0.
REQ-033 rst=1 with en=1 during RUN -> next cycle all registers at reset values, busy=0; with en still 1 after rst release, RUN entered per REQ-013.

Source files
------------

// File: rtl/ask_fsk_modulator.sv
// ASK/FSK modulator: triangle carrier whose step and gating follow the serial bit
// latched at each bit boundary.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | output silent, waiting for en; carrier state frozen
// RUN   | bit timer and carrier running, mod_out driven by latched bit
module ask_fsk_modulator #(
  parameter int BIT_CYCLES = 1024,
  parameter int STEP_HI    = 8,
  parameter int STEP_LO    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       ser_in,
  output logic [7:0] mod_out,
  output logic       bit_strobe,
  output logic       busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [9:0] TIMER_LAST = 10'(BIT_CYCLES - 1);
  localparam logic [8:0] S_HI       = 9'(STEP_HI);
  localparam logic [8:0] S_LO       = 9'(STEP_LO);

  state_t     state;
  logic [9:0] timer;
  logic [7:0] acc;
  logic       dir_down;
  logic       cur_bit;
  logic       mode_q;

  logic [8:0] step;
  logic [8:0] acc_up;
  logic [7:0] acc_dn;

  always_comb begin
    step   = (mode_q && !cur_bit) ? S_LO : S_HI;
    acc_up = {1'b0, acc} + step;
    acc_dn = acc - step[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      acc        <= '0;
      dir_down   <= 1'b0;
      cur_bit    <= 1'b0;
      mode_q     <= 1'b0;
      bit_strobe <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state      <= RUN;
            cur_bit    <= ser_in;
            mode_q     <= mode;
            timer      <= '0;
            acc        <= '0;
            dir_down   <= 1'b0;
            bit_strobe <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
          end else begin
            // Carrier keeps moving on the wrap cycle too, so phase is continuous.
            if (!dir_down) begin
              if (acc_up > 9'd255) begin
                acc      <= 8'd255;
                dir_down <= 1'b1;
              end else begin
                acc <= acc_up[7:0];
              end
            end else begin
              if ({1'b0, acc} < step) begin
                acc      <= '0;
                dir_down <= 1'b0;
              end else begin
                acc <= acc_dn;
              end
            end
            if (timer == TIMER_LAST) begin
              timer      <= '0;
              cur_bit    <= ser_in;
              mode_q     <= mode;
              bit_strobe <= 1'b1;
            end else begin
              timer <= timer + 10'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state == RUN);
    mod_out = '0;
    if (state == RUN && (mode_q || cur_bit)) mod_out = acc;
  end

endmodule
